// File: rtl/cntr_modulus_prog.sv
`default_nettype none
// ============================================================================
// Module      : cntr_modulus_prog
// Description : Runtime-programmable modulus counter. Counts up or down
//               within [0, mod_active-1], supports synchronous clear and
//               parallel load, and exposes a combinational terminal count
//               for cascading. A new modulus captured with ModUpdate is held
//               pending and only takes effect at a boundary (wrap, clear or
//               load), so the count sequence never glitches mid-period.
//
// Ports       : Clk, Reset       - clock, synchronous active-high reset
//               Enable           - count enable
//               sClear           - synchronous clear (ignores Enable)
//               Load, LoadVal    - parallel load, clamped to the period
//               Dir              - 0 = up, 1 = down
//               ModVal, ModUpdate- requested modulus (0 = 2^WIDTH) + strobe
//               q                - registered count
//               tc               - combinational terminal count
//               wrap             - registered one-cycle wrap pulse
//               wrap_count       - wraps since reset/clear (rolls over)
//               mod_active       - modulus currently in force
//               mod_pending      - a captured modulus awaits a boundary
//
// Revision    : 1.0 - initial release
// ============================================================================
module cntr_modulus_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_MOD = 16,
    parameter int WRAP_CNT_W  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  sClear,
    input  logic                  Load,
    input  logic [WIDTH-1:0]      LoadVal,
    input  logic                  Dir,
    input  logic [WIDTH-1:0]      ModVal,
    input  logic                  ModUpdate,
    output logic [WIDTH-1:0]      q,
    output logic                  tc,
    output logic                  wrap,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0]      mod_active,
    output logic                  mod_pending
);

    localparam logic [WIDTH-1:0]      c_DEFAULT_MOD = WIDTH'(DEFAULT_MOD);
    localparam logic [WIDTH-1:0]      c_ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WRAP_CNT_W-1:0] c_WC_ONE      = {{(WRAP_CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      r_q;
    logic                  r_wrap;
    logic [WRAP_CNT_W-1:0] r_wrap_count;
    logic [WIDTH-1:0]      r_mod_active;
    logic [WIDTH-1:0]      r_pend_val;
    logic                  r_mod_pending;

    logic [WIDTH-1:0]      w_last;
    logic [WIDTH-1:0]      w_mod_new;
    logic [WIDTH-1:0]      w_last_new;
    logic [WIDTH-1:0]      w_load_q;
    logic                  w_wrap_hit;
    logic                  w_count;
    logic                  w_apply;

    // Modulus 0 naturally yields last = all-ones through WIDTH-bit wraparound.
    assign w_last     = r_mod_active - c_ONE;
    // Modulus that will be in force after a boundary on this edge.
    assign w_mod_new  = r_mod_pending ? r_pend_val : r_mod_active;
    assign w_last_new = w_mod_new - c_ONE;
    assign w_load_q   = (LoadVal > w_last_new) ? w_last_new : LoadVal;

    // Up: q above last (possible after a shrink) wraps too. Down: wrap at 0.
    assign w_wrap_hit = Dir ? (r_q == '0) : (r_q >= w_last);
    assign w_count    = Enable & ~sClear & ~Load;
    assign tc         = w_count & w_wrap_hit;
    // Any boundary at which a pending modulus is allowed to take effect.
    assign w_apply    = sClear | Load | tc;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_q           <= '0;
            r_wrap        <= 1'b0;
            r_wrap_count  <= '0;
            r_mod_active  <= c_DEFAULT_MOD;
            r_pend_val    <= '0;
            r_mod_pending <= 1'b0;
        end else begin
            if (sClear) begin
                r_q          <= '0;
                r_wrap_count <= '0;
                r_wrap       <= 1'b0;
            end else if (Load) begin
                r_q    <= w_load_q;
                r_wrap <= 1'b0;
            end else if (Enable) begin
                if (w_wrap_hit) begin
                    r_q          <= Dir ? w_last_new : '0;
                    r_wrap       <= 1'b1;
                    r_wrap_count <= r_wrap_count + c_WC_ONE;
                end else begin
                    r_wrap <= 1'b0;
                    if (!Dir) begin
                        r_q <= r_q + c_ONE;
                    end else if (r_q > w_last) begin
                        // Down-counting after a shrink: snap into range first.
                        r_q <= w_last;
                    end else begin
                        r_q <= r_q - c_ONE;
                    end
                end
            end else begin
                r_wrap <= 1'b0;
            end

            if (w_apply) begin
                r_mod_active <= w_mod_new;
            end

            // A strobe coinciding with a boundary becomes the next pending
            // value; the previously pending one is the one applied above.
            if (ModUpdate) begin
                r_pend_val    <= ModVal;
                r_mod_pending <= 1'b1;
            end else if (w_apply) begin
                r_mod_pending <= 1'b0;
            end
        end
    end

    assign q           = r_q;
    assign wrap        = r_wrap;
    assign wrap_count  = r_wrap_count;
    assign mod_active  = r_mod_active;
    assign mod_pending = r_mod_pending;

endmodule
`default_nettype wire

// File: tb/tb_cntr_modulus_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_cntr_modulus_prog
// Description : Scoreboard bench for cntr_modulus_prog. A driver applies
//               directed and random stimulus on the falling edge, advances a
//               behavioural model and queues the expected response; a
//               separate monitor pops and compares tc before the rising edge
//               and the registered outputs just after it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cntr_modulus_prog;

    localparam int WIDTH = 8;
    localparam int DEF   = 16;
    localparam int WCW   = 16;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Enable = 1'b0, sClear = 1'b0, Load = 1'b0, Dir = 1'b0, ModUpdate = 1'b0;
    logic [WIDTH-1:0] LoadVal = '0, ModVal = '0;
    logic [WIDTH-1:0] q, mod_active;
    logic             tc, wrap, mod_pending;
    logic [WCW-1:0]   wrap_count;

    cntr_modulus_prog #(.WIDTH(WIDTH), .DEFAULT_MOD(DEF), .WRAP_CNT_W(WCW)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .sClear(sClear), .Load(Load),
        .LoadVal(LoadVal), .Dir(Dir), .ModVal(ModVal), .ModUpdate(ModUpdate),
        .q(q), .tc(tc), .wrap(wrap), .wrap_count(wrap_count),
        .mod_active(mod_active), .mod_pending(mod_pending)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int tc;
        int q;
        int wrap;
        int wc;
        int ma;
        int mp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state: plain integers; modulus kept as programmed (0 = 256).
    int m_q = 0, m_wrap = 0, m_wc = 0, m_mod = DEF, m_pv = 0, m_pval = 0;

    function automatic int last_of(input int m);
        return ((m == 0) ? (1 << WIDTH) : m) - 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, predict, enqueue.
    task automatic step(input bit rst, input bit en, input bit clr, input bit ld,
                        input bit dir, input bit mu, input int lv, input int mv);
        exp_t e;
        int   newmod;
        bit   applied;
        @(negedge Clk);
        Reset = rst; Enable = en; sClear = clr; Load = ld; Dir = dir;
        ModUpdate = mu; LoadVal = WIDTH'(lv); ModVal = WIDTH'(mv);

        e.tc = (en && !clr && !ld && (dir ? (m_q == 0) : (m_q >= last_of(m_mod)))) ? 1 : 0;
        if (rst) begin
            m_q = 0; m_wrap = 0; m_wc = 0; m_mod = DEF; m_pv = 0; m_pval = 0;
        end else begin
            newmod  = m_pv ? m_pval : m_mod;
            applied = 1'b0;
            m_wrap  = 0;
            if (clr) begin
                m_q = 0; m_wc = 0; applied = 1'b1;
            end else if (ld) begin
                m_q = (lv < last_of(newmod)) ? lv : last_of(newmod);
                applied = 1'b1;
            end else if (en) begin
                if (!dir) begin
                    if (m_q >= last_of(m_mod)) begin
                        m_q = 0; m_wrap = 1; applied = 1'b1;
                    end else m_q = m_q + 1;
                end else begin
                    if (m_q == 0) begin
                        m_q = last_of(newmod); m_wrap = 1; applied = 1'b1;
                    end else if (m_q > last_of(m_mod)) m_q = last_of(m_mod);
                    else m_q = m_q - 1;
                end
                if (m_wrap == 1) m_wc = (m_wc + 1) % (1 << WCW);
            end
            if (applied) m_mod = newmod;
            if (mu) begin
                m_pval = mv; m_pv = 1;
            end else if (applied) m_pv = 0;
        end
        e.q = m_q; e.wrap = m_wrap; e.wc = m_wc; e.ma = m_mod; e.mp = m_pv;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input bit dir);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, dir, 0, 0, 0);
    endtask

    task automatic run_to_q(input int target);
        for (int i = 0; i < 600 && m_q != target; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: independent of the driver, consumes one record per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tc", int'(tc), e.tc);
                @(posedge Clk);
                #1;
                chk("q", int'(q), e.q);
                chk("wrap", int'(wrap), e.wrap);
                chk("wrap_count", int'(wrap_count), e.wc);
                chk("mod_active", int'(mod_active), e.ma);
                chk("mod_pending", int'(mod_pending), e.mp);
            end
        end
    end

    initial begin
        int drain;
        // 1: reset, idle
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // 2: count up through one wrap
        run(20, 0);
        // 3: shrink to 5 at next wrap, then count down
        step(0, 1, 0, 0, 0, 1, 0, 5);
        for (int i = 0; i < 40 && m_pv != 0; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        run(7, 1);
        // 4a: ModUpdate mid-period
        step(1, 0, 0, 0, 0, 0, 0, 0);
        run_to_q(7);
        step(0, 1, 0, 0, 0, 1, 0, 3);
        run(12, 0);
        // 4b: ModUpdate on the wrap edge
        step(1, 0, 0, 0, 0, 0, 0, 0);
        run_to_q(15);
        step(0, 1, 0, 0, 0, 1, 0, 3);
        run(22, 0);
        // 5: load clamp, load+clear, load while disabled
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 20, 0);
        run(3, 0);
        step(0, 1, 1, 1, 0, 0, 9, 0);
        step(0, 0, 0, 1, 0, 0, 9, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // 6: full-range modulus, hold, reset with pending modulus
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 40 && m_pv != 0; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        run_to_q(255);
        run(2, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        run_to_q(100);
        step(0, 1, 0, 0, 0, 1, 0, 7);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Random phase: small moduli so boundaries happen often
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 7) == 0) ? ~Dir : Dir,
                 ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 255),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        drain = 0;
        while (exp_q.size() > 0 && drain < 20) begin
            @(posedge Clk);
            drain++;
        end
        repeat (2) @(posedge Clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
